// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream while holding
// the core in reset. Stream: count low byte, count high byte, then N words of
// four bytes each, least-significant byte first.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the XOR of all payload bytes before the core is released.
//
// Handshake: a byte is consumed on every rising edge where
// byte_valid && byte_ready. byte_ready is a pure decode of the state, so the
// source can stream one byte per cycle and must hold byte_data until consumed.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH_WORDS);

    state_t      state;
    state_t      next_state;
    logic [7:0]  n_lo;          // low count byte held until the high byte arrives
    logic [15:0] n_words;       // word count of the current session
    logic [15:0] word_cnt;      // words written so far
    logic [1:0]  idx;           // byte lane of the next payload byte
    logic [23:0] lanes;         // lanes 0..2 of the word being assembled
    logic [31:0] waddr;         // address of the next write
    logic [15:0] hdr_count;
    logic        last_word;
    logic        start_session;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;          // running XOR of payload bytes
`endif

    assign hdr_count     = {byte_data, n_lo};
    assign last_word     = (word_cnt == (n_words - 16'd1));
    assign start_session = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the combinational handshake and busy outputs
    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) next_state = S_HDR0;
            end
            S_HDR0: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) next_state = S_HDR1;
            end
            S_HDR1: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if ((hdr_count == 16'd0) || (hdr_count > DEPTH_W)) next_state = S_ERR;
                    else                                                next_state = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && (idx == 2'd3) && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = S_CSUM;
`else
                    next_state = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) next_state = (byte_data == csum) ? S_DONE : S_ERR;
            end
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: header capture, word assembly, write issue, status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            n_lo       <= 8'd0;
            n_words    <= 16'd0;
            word_cnt   <= 16'd0;
            idx        <= 2'd0;
            lanes      <= 24'd0;
            waddr      <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            // The core runs only while idle or after a clean load
            cpu_rst_n <= (state == S_IDLE) || (state == S_DONE);
            if (start_session) begin
                done     <= 1'b0;
                error    <= 1'b0;
                waddr    <= BASE_ADDR;
                word_cnt <= 16'd0;
                idx      <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end
            if ((state == S_HDR0) && byte_valid) n_lo <= byte_data;
            if ((state == S_HDR1) && byte_valid) n_words <= hdr_count;
            if ((state == S_DATA) && byte_valid) begin
                idx <= idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum <= csum ^ byte_data;
`endif
                if (idx == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= {byte_data, lanes};
                    imem_addr  <= waddr;
                    waddr      <= waddr + 32'd4;
                    word_cnt   <= word_cnt + 16'd1;
                end else begin
                    // Shift in from the top so lane 0 ends up in bits [7:0]
                    lanes <= {byte_data, lanes[23:8]};
                end
            end
            if ((next_state == S_DONE) && (state != S_DONE)) done  <= 1'b1;
            if ((next_state == S_ERR)  && (state != S_ERR))  error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven sessions plus hand-written corner sequences.
// Every written word is pushed to exp_q when it is driven and popped by the
// write monitor when imem_we is seen.
module tb_imem_loader;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Clock
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [7:0]  acc;
    logic [63:0] mon_e;

    typedef struct {
        logic [15:0] n;
        int          nw;
        bit          gap;
        bit          exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h, want no write", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", imem_addr, mon_e[63:32]);
                check("write_data", imem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic wait_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until consumed; optional idle cycle first
    task automatic send_byte(input logic [7:0] b, input bit gap);
        logic ready_seen;
        int   t;
        if (gap) begin
            byte_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        do begin
            ready_seen = byte_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ready_seen && t < 50);
        if (!ready_seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_timeout: got byte_ready 0 for 50 cycles, want 1");
        end
        byte_valid = 1'b0;
    endtask

    task automatic begin_session();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_addr = BASE;
        acc = 8'd0;
    endtask

    task automatic send_header(input logic [15:0] n, input bit gap);
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        exp_q.push_back({exp_addr, w});
        exp_addr += 32'd4;
        for (int i = 0; i < 4; i++) begin
            acc ^= w[i*8 +: 8];
            send_byte(w[i*8 +: 8], gap);
        end
    endtask

    // Trailer that closes a clean session
    task automatic end_payload(input bit gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(acc, gap);
`else
        if (gap) wait_cycles(1);
`endif
    endtask

    task automatic check_end(input string tag, input bit exp_done);
        wait_cycles(3);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(!exp_done));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;

        vecs[0] = '{16'd1,     1, 1'b0, 1'b1};
        vecs[1] = '{16'd8,     8, 1'b0, 1'b1};
        vecs[2] = '{16'd3,     3, 1'b1, 1'b1};
        vecs[3] = '{16'd0,     0, 1'b0, 1'b0};
        vecs[4] = '{16'd9,     0, 1'b0, 1'b0};
        vecs[5] = '{16'h0108,  0, 1'b1, 1'b0};

        // Reset values
        #12;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", imem_addr, BASE);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bytes offered while idle are not taken; core runs while idle
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        wait_cycles(3);
        check("idle_byte_ready", 32'(byte_ready), 32'd0);
        check("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        byte_valid = 1'b0;

        // Reference program, back-to-back
        begin_session();
        check("hdr0_busy", 32'(busy), 32'd1);
        send_header(16'd2, 1'b0);
        check("load_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        send_word(32'h0050_0513, 1'b0);
        send_word(32'h00A0_0593, 1'b0);
        end_payload(1'b0);
        check_end("ref", 1'b1);

        // Same program with valid toggling every other cycle
        begin_session();
        send_header(16'd2, 1'b1);
        send_word(32'h0050_0513, 1'b1);
        send_word(32'h00A0_0593, 1'b1);
        end_payload(1'b1);
        check_end("gap", 1'b1);

        // Table of sessions
        for (int v = 0; v < 6; v++) begin
            begin_session();
            send_header(vecs[v].n, vecs[v].gap);
            for (int k = 0; k < vecs[v].nw; k++) send_word($urandom(), vecs[v].gap);
            if (vecs[v].exp_done) end_payload(vecs[v].gap);
            check_end($sformatf("vec%0d", v), vecs[v].exp_done);
        end

        // Reset after six payload bytes, then a fresh one-word load
        begin_session();
        send_header(16'd2, 1'b0);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_byte_ready", 32'(byte_ready), 32'd0);
        check("midrst_imem_addr", imem_addr, BASE);
        check("midrst_imem_wdata", imem_wdata, 32'd0);
        check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(2);
        begin_session();
        send_header(16'd1, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        end_payload(1'b0);
        check_end("after_rst", 1'b1);

        // start pulsed in the middle of a word is ignored
        begin_session();
        send_header(16'd2, 1'b0);
        w = 32'hCAFE_F00D;
        exp_q.push_back({exp_addr, w});
        exp_addr += 32'd4;
        for (int i = 0; i < 4; i++) begin
            acc ^= w[i*8 +: 8];
            if (i == 2) start = 1'b1;
            send_byte(w[i*8 +: 8], 1'b0);
            start = 1'b0;
        end
        send_word(32'h0BAD_C0DE, 1'b0);
        end_payload(1'b0);
        check_end("mid_start", 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Correct and wrong trailer for word 01 02 03 04
        begin_session();
        send_header(16'd1, 1'b0);
        send_word(32'h0403_0201, 1'b0);
        send_byte(8'h04, 1'b0);
        check_end("csum_ok", 1'b1);
        begin_session();
        send_header(16'd1, 1'b0);
        send_word(32'h0403_0201, 1'b0);
        send_byte(8'h05, 1'b0);
        check_end("csum_bad", 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
